// File: rtl/m68k_bus_arbiter.sv
// Shares the 68000 bus between the CPU and two alternate masters via BRn/BGn/BGACKn.
// Round-robin between masters, with an optional tenure limit that forces the bus back to the CPU.
module m68k_bus_arbiter #(
  parameter int unsigned MAX_HOLD = 256,
  parameter int unsigned CNT_W    = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [1:0] mbusy,
  input  logic       BGn,
  input  logic       ASn,
  output logic       BRn,
  output logic       BGACKn,
  output logic [1:0] gnt,
  output logic       expire
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam bit             HOLD_EN  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LIM = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state, state_n;
  logic             sel, sel_n;
  logic             last, last_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             brn_n, bgackn_n, expire_n;
  logic [1:0]       gnt_n;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
      BRn    <= 1'b1;
      BGACKn <= 1'b1;
      gnt    <= 2'b00;
      expire <= 1'b0;
    end else begin
      state  <= state_n;
      sel    <= sel_n;
      last   <= last_n;
      cnt    <= cnt_n;
      BRn    <= brn_n;
      BGACKn <= bgackn_n;
      gnt    <= gnt_n;
      expire <= expire_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n  = state;
    sel_n    = sel;
    last_n   = last;
    cnt_n    = cnt;
    brn_n    = BRn;
    bgackn_n = BGACKn;
    gnt_n    = gnt;
    expire_n = expire;

    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          sel_n   = (req == 2'b11) ? ~last : req[1];
          brn_n   = 1'b0;
          state_n = REQ;
        end
      end

      REQ: begin
        if (!req[sel]) begin
          // Selected master withdrew: hand the pending request to the other one if it wants it
          if (req[~sel]) begin
            sel_n = ~sel;
          end else begin
            brn_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (!BGn && ASn) begin
          bgackn_n = 1'b0;
          brn_n    = 1'b1;
          gnt_n    = sel ? 2'b10 : 2'b01;
          cnt_n    = '0;
          expire_n = HOLD_EN && (HOLD_LIM == '0);
          state_n  = OWN;
        end
      end

      OWN: begin
        cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        if (!req[sel] || (expire && !mbusy[sel])) begin
          gnt_n    = 2'b00;
          bgackn_n = 1'b1;
          expire_n = 1'b0;
          state_n  = RELEASE;
        end else begin
          expire_n = HOLD_EN && (cnt_n >= HOLD_LIM);
        end
      end

      RELEASE: begin
        last_n  = sel;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed and soak checks for m68k_bus_arbiter with a tenure limit of 8 cycles.
module tb_m68k_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] mbusy;
  logic       BGn;
  logic       ASn;
  logic       BRn;
  logic       BGACKn;
  logic [1:0] gnt;
  logic       expire;

  int checks = 0;
  int errors = 0;

  m68k_bus_arbiter #(.MAX_HOLD(8), .CNT_W(9)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .mbusy  (mbusy),
    .BGn    (BGn),
    .ASn    (ASn),
    .BRn    (BRn),
    .BGACKn (BGACKn),
    .gnt    (gnt),
    .expire (expire)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst   = 1'b1;
    req   = 2'b00;
    mbusy = 2'b00;
    BGn   = 1'b1;
    ASn   = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Advance until grant presence matches want_nonzero; n = cycles taken (40 = timed out)
  task automatic wait_gnt(input bit want_nonzero, output int n);
    n = 0;
    while (((gnt != 2'b00) != want_nonzero) && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    apply_reset;
    checks++;
    if ({BRn, BGACKn, gnt, expire} !== 5'b11_00_0) begin
      errors++;
      $display("FAIL reset_state: BRn/BGACKn/gnt/expire=%b required 11000", {BRn, BGACKn, gnt, expire});
    end
    tick;
    checks++;
    if ({BRn, BGACKn, gnt} !== 4'b11_00) begin
      errors++;
      $display("FAIL reset_idle: BRn/BGACKn/gnt=%b required 1100", {BRn, BGACKn, gnt});
    end
  endtask

  task automatic test_single;
    apply_reset;
    req = 2'b01;
    tick;
    checks++;
    if (BRn !== 1'b0 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL single_brn: BRn=%b gnt=%b required BRn=0 gnt=00", BRn, gnt);
    end
    BGn = 1'b0;
    tick;
    checks++;
    if (gnt !== 2'b01 || BGACKn !== 1'b0 || BRn !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: gnt=%b BGACKn=%b BRn=%b required 01/0/1", gnt, BGACKn, BRn);
    end
    BGn = 1'b1;
    req = 2'b00;
    tick;
    checks++;
    if (gnt !== 2'b00 || BGACKn !== 1'b1 || BRn !== 1'b1) begin
      errors++;
      $display("FAIL single_release: gnt=%b BGACKn=%b BRn=%b required 00/1/1", gnt, BGACKn, BRn);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    apply_reset;
    req = 2'b11;
    BGn = 1'b0;
    tick;
    tick;
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("FAIL tie_first: gnt=%b required 01", gnt);
    end
    for (int r = 0; r < 2; r++) begin
      wait_gnt(1'b0, n);
      checks++;
      if (n !== 8) begin
        errors++;
        $display("FAIL b2b_tenure%0d: cycles=%0d required 8", r, n);
      end
      wait_gnt(1'b1, n);
      checks++;
      if (n !== 3) begin
        errors++;
        $display("FAIL b2b_gap%0d: cycles=%0d required 3", r, n);
      end
      checks++;
      if (gnt !== ((r == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL b2b_alt%0d: gnt=%b required %b", r, gnt, (r == 0) ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic test_bus_busy;
    apply_reset;
    req = 2'b01;
    tick;
    BGn = 1'b0;
    ASn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (gnt !== 2'b00 || BRn !== 1'b0 || BGACKn !== 1'b1) begin
        errors++;
        $display("FAIL busy_wait%0d: gnt=%b BRn=%b BGACKn=%b required 00/0/1", i, gnt, BRn, BGACKn);
      end
    end
    ASn = 1'b1;
    tick;
    checks++;
    if (gnt !== 2'b01 || BGACKn !== 1'b0) begin
      errors++;
      $display("FAIL busy_grant: gnt=%b BGACKn=%b required 01/0", gnt, BGACKn);
    end
  endtask

  task automatic test_expire;
    logic       exp_e;
    logic [1:0] exp_g;
    // Unblocked: expire on OWN cycle 8, bus gone on cycle 9
    apply_reset;
    req = 2'b01;
    BGn = 1'b0;
    tick;
    tick;
    for (int k = 1; k <= 9; k++) begin
      exp_e = (k == 8);
      exp_g = (k <= 8) ? 2'b01 : 2'b00;
      checks++;
      if (expire !== exp_e || gnt !== exp_g) begin
        errors++;
        $display("FAIL expire_free_c%0d: expire=%b gnt=%b required %b/%b", k, expire, gnt, exp_e, exp_g);
      end
      tick;
    end
    // mbusy held through cycle 10 delays release by 3 cycles
    apply_reset;
    req = 2'b01;
    BGn = 1'b0;
    tick;
    tick;
    for (int k = 1; k <= 12; k++) begin
      mbusy = (k <= 10) ? 2'b01 : 2'b00;
      exp_e = (k >= 8 && k <= 11);
      exp_g = (k <= 11) ? 2'b01 : 2'b00;
      checks++;
      if (expire !== exp_e || gnt !== exp_g) begin
        errors++;
        $display("FAIL expire_busy_c%0d: expire=%b gnt=%b required %b/%b", k, expire, gnt, exp_e, exp_g);
      end
      tick;
    end
  endtask

  task automatic test_withdraw;
    apply_reset;
    req = 2'b01;
    tick;
    req = 2'b00;
    tick;
    checks++;
    if (BRn !== 1'b1 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL withdraw_brn: BRn=%b gnt=%b required 1/00", BRn, gnt);
    end
    BGn = 1'b0;
    tick;
    checks++;
    if (BRn !== 1'b1 || gnt !== 2'b00 || BGACKn !== 1'b1) begin
      errors++;
      $display("FAIL withdraw_idle: BRn=%b gnt=%b BGACKn=%b required 1/00/1", BRn, gnt, BGACKn);
    end
    BGn = 1'b1;
    req = 2'b01;
    tick;
    req = 2'b10;
    tick;
    checks++;
    if (BRn !== 1'b0 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL switch_req: BRn=%b gnt=%b required 0/00", BRn, gnt);
    end
    BGn = 1'b0;
    tick;
    checks++;
    if (gnt !== 2'b10 || BGACKn !== 1'b0) begin
      errors++;
      $display("FAIL switch_grant: gnt=%b BGACKn=%b required 10/0", gnt, BGACKn);
    end
  endtask

  task automatic test_reset_own;
    apply_reset;
    req   = 2'b10;
    mbusy = 2'b10;
    BGn   = 1'b0;
    tick;
    tick;
    for (int k = 1; k < 9; k++) tick;
    checks++;
    if (expire !== 1'b1 || gnt !== 2'b10) begin
      errors++;
      $display("FAIL pre_reset_own: expire=%b gnt=%b required 1/10", expire, gnt);
    end
    rst = 1'b1;
    tick;
    checks++;
    if ({BRn, BGACKn, gnt, expire} !== 5'b11_00_0) begin
      errors++;
      $display("FAIL reset_own: BRn/BGACKn/gnt/expire=%b required 11000", {BRn, BGACKn, gnt, expire});
    end
    rst = 1'b0;
  endtask

  task automatic test_soak;
    int  hi_run;
    logic prev_bgackn;
    apply_reset;
    hi_run      = 100;
    prev_bgackn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) BGn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) ASn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) mbusy = 2'($urandom_range(0, 3));
      tick;
      checks++;
      if (gnt == 2'b11 || ((gnt != 2'b00) != (BGACKn == 1'b0)) || (BRn == 1'b0 && BGACKn == 1'b0)) begin
        errors++;
        $display("FAIL soak_invariant@%0d: gnt=%b BGACKn=%b BRn=%b", i, gnt, BGACKn, BRn);
      end
      if (BGACKn == 1'b0 && prev_bgackn == 1'b1) begin
        checks++;
        if (hi_run < 2) begin
          errors++;
          $display("FAIL soak_gap@%0d: BGACKn high run=%0d required >=2", i, hi_run);
        end
      end
      hi_run      = BGACKn ? hi_run + 1 : 0;
      prev_bgackn = BGACKn;
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = 2'b00;
    mbusy = 2'b00;
    BGn   = 1'b1;
    ASn   = 1'b1;
    test_reset;
    test_single;
    test_back_to_back;
    test_bus_busy;
    test_expire;
    test_withdraw;
    test_reset_own;
    test_soak;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
